// File: rtl/cond_unit_pkg.sv
// Shared condition-code encodings and flag bit positions for the
// condition unit and the ALU flag packing.
package cond_unit_pkg;

    // Flag bit positions inside the {N,Z,C,V} nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Pack individual ALU flags into the architectural nibble order
    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/cond_unit_check.sv
// Combinational condition evaluator: cond field against current flags.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       c
);

    logic n, z, cf, v;

    assign n  = flags[FLAG_N];
    assign z  = flags[FLAG_Z];
    assign cf = flags[FLAG_C];
    assign v  = flags[FLAG_V];

    // Decode the condition field into a single pass/fail bit
    always_comb begin
        c = 1'b0;
        case (cond_e'(cond))
            COND_EQ: c = z;
            COND_NE: c = ~z;
            COND_CS: c = cf;
            COND_CC: c = ~cf;
            COND_MI: c = n;
            COND_PL: c = ~n;
            COND_VS: c = v;
            COND_VC: c = ~v;
            COND_HI: c = cf & ~z;
            COND_LS: c = ~cf | z;
            COND_GE: c = (n == v);
            COND_LT: c = (n != v);
            COND_GT: c = ~z & (n == v);
            COND_LE: c = z | (n != v);
            COND_AL: c = 1'b1;
            COND_NV: c = 1'b0;
            default: c = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates the condition against the flag
// register, gates the write enables, updates flags and counts squashes.
// One-entry output register with a valid/ready handshake.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_w,
    input  logic [3:0]       alu_flags,
    input  logic             pc_s,
    input  logic             reg_w,
    input  logic             mem_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] squash_cnt
);

    logic c;
    logic acc;

    cond_check u_check (
        .cond  (cond),
        .flags (flags),
        .c     (c)
    );

    // Ready when the output slot is empty or draining; never during reset
    assign in_ready = reset & (~out_valid | out_ready);
    assign acc      = in_valid & in_ready;

    // Output register and handshake state
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
            cond_ex   <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            pc_src    <= pc_s  & c;
            reg_write <= reg_w & c;
            mem_write <= mem_w & c;
            cond_ex   <= c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Architectural flags: only a passing instruction may write them
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else if (acc && c) begin
            if (flag_w[1]) begin
                flags[FLAG_N] <= alu_flags[FLAG_N];
                flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_w[0]) begin
                flags[FLAG_C] <= alu_flags[FLAG_C];
                flags[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    // Saturating count of squashed (condition-failed) instructions
    always_ff @(posedge clk) begin
        if (!reset) begin
            squash_cnt <= '0;
        end else if (acc && !c && (squash_cnt != {CNT_W{1'b1}})) begin
            squash_cnt <= squash_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (default width plus a
// 2-bit counter instance for saturation).
module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] cond;
    logic [1:0] flag_w;
    logic [3:0] alu_flags;
    logic       pc_s, reg_w, mem_w;
    logic       out_ready;

    logic       in_ready, out_valid, pc_src, reg_write, mem_write, cond_ex;
    logic [3:0] flags;
    logic [7:0] squash_cnt;

    logic       in_ready2, out_valid2, pc_src2, reg_write2, mem_write2, cond_ex2;
    logic [3:0] flags2;
    logic [1:0] squash_cnt2;

    int tests  = 0;
    int failed = 0;

    cond_unit #(.CNT_W(8)) u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .flag_w(flag_w), .alu_flags(alu_flags),
        .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
        .cond_ex(cond_ex), .flags(flags), .squash_cnt(squash_cnt)
    );

    cond_unit #(.CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .cond(cond), .flag_w(flag_w), .alu_flags(alu_flags),
        .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w),
        .out_valid(out_valid2), .out_ready(out_ready),
        .pc_src(pc_src2), .reg_write(reg_write2), .mem_write(mem_write2),
        .cond_ex(cond_ex2), .flags(flags2), .squash_cnt(squash_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] cd, input logic [1:0] fw,
                         input logic [3:0] af, input logic p, input logic r, input logic m);
        in_valid  = v;
        cond      = cd;
        flag_w    = fw;
        alu_flags = af;
        pc_s      = p;
        reg_w     = r;
        mem_w     = m;
    endtask

    // Expected c for every cond code with flags = 1100 (N=1 Z=1 C=0 V=0)
    logic [15:0] exp_1100;
    int          exp_sq;

    initial begin
        exp_1100 = 16'b0110_1010_1001_1001; // bit i = expected c for cond i
        exp_sq   = 0;

        // Reset with an instruction presented: must not be accepted
        reset     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_flags", 32'(flags), 'b0000);
        chk("rst_squash", 32'(squash_cnt), 0);
        chk("rst_cond_ex", 32'(cond_ex), 0);
        chk("rst_writes", 32'({pc_src, reg_write, mem_write}), 0);
        reset = 1'b1;

        // AL with full flag write, then EQ sees the new Z
        drive(1'b1, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0);
        #1;
        chk("ready_idle", 32'(in_ready), 1);
        tick();
        chk("al_valid", 32'(out_valid), 1);
        chk("al_cond_ex", 32'(cond_ex), 1);
        chk("al_flags", 32'(flags), 'b0100);
        chk("al_reg_write", 32'(reg_write), 1);
        drive(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        chk("eq_cond_ex", 32'(cond_ex), 1);
        chk("eq_writes", 32'({pc_src, reg_write, mem_write}), 'b111);
        chk("eq_flags_hold", 32'(flags), 'b0100);

        // Clear flags, then a failing EQ must squash and not write flags
        drive(1'b1, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("clr_flags", 32'(flags), 'b0000);
        drive(1'b1, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b1);
        tick();
        exp_sq++;
        chk("sq_cond_ex", 32'(cond_ex), 0);
        chk("sq_writes", 32'({reg_write, mem_write}), 0);
        chk("sq_flags", 32'(flags), 'b0000);
        chk("sq_cnt", 32'(squash_cnt), 1);

        // flags=1001: GE true, LT false, GT true
        drive(1'b1, 4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0);
        tick();
        chk("set_1001", 32'(flags), 'b1001);
        drive(1'b1, 4'b1010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ge_1001", 32'(cond_ex), 1);
        drive(1'b1, 4'b1011, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        exp_sq++;
        chk("lt_1001", 32'(cond_ex), 0);
        drive(1'b1, 4'b1100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("gt_1001", 32'(cond_ex), 1);

        // flags=1100: sweep every cond code back-to-back
        drive(1'b1, 4'b1110, 2'b11, 4'b1100, 1'b0, 1'b0, 1'b0);
        tick();
        chk("set_1100", 32'(flags), 'b1100);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 2'b00, 4'b0011, 1'b0, 1'b1, 1'b0);
            tick();
            if (!exp_1100[i]) exp_sq++;
            chk($sformatf("sweep_c%0d", i), 32'(cond_ex), 32'(exp_1100[i]));
            chk($sformatf("sweep_rw%0d", i), 32'(reg_write), 32'(exp_1100[i]));
        end
        chk("sweep_squash", 32'(squash_cnt), 32'(exp_sq));
        chk("sweep_flags_hold", 32'(flags), 'b1100);

        // Backpressure: last output was NV (cond_ex=0), hold 3 cycles
        out_ready = 1'b0;
        drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_ready%0d", i), 32'(in_ready), 0);
            chk($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
            chk($sformatf("bp_outs%0d", i), 32'({cond_ex, pc_src, reg_write, mem_write}), 0);
            chk($sformatf("bp_flags%0d", i), 32'(flags), 'b1100);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        chk("bp_load_valid", 32'(out_valid), 1);
        chk("bp_load_outs", 32'({cond_ex, pc_src, reg_write, mem_write}), 'b1111);
        chk("bp_load_flags", 32'(flags), 'b1111);

        // Drain with in_valid=0: output clears, flags ignore inputs
        drive(1'b0, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("drain_valid", 32'(out_valid), 0);
        chk("idle_flags", 32'(flags), 'b1111);
        chk("idle_squash", 32'(squash_cnt), 32'(exp_sq));

        // Reset while an output is held and a flag write is presented
        drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("held_valid", 32'(out_valid), 1);
        reset = 1'b0;
        drive(1'b1, 4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0);
        tick();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_flags", 32'(flags), 'b0000);
        chk("midrst_squash", 32'(squash_cnt), 0);
        reset     = 1'b1;
        out_ready = 1'b1;

        // Saturation on the 2-bit counter: 5 NV accepts
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b1111, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1);
            tick();
            chk($sformatf("sat2_%0d", i), 32'(squash_cnt2), (i < 3) ? i + 1 : 3);
            chk($sformatf("cnt8_%0d", i), 32'(squash_cnt), i + 1);
        end
        chk("nv_flags", 32'(flags2), 'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
